// File: rtl/inst_ctrl_pkg.sv
// Shared definitions for the instruction-side control blocks (PC sequencer,
// loop controller, decoder): sequencer state encoding and default sizes.
package inst_ctrl_pkg;

    localparam int unsigned InstMemDepthDef = 256;
    localparam int unsigned InstWidthDef    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } inst_state_e;

endpackage

// File: rtl/inst_pc_control_if.sv
// Instruction-path bus around the PC sequencer: loop-controller handshake,
// instruction-memory read port and decoder output. The master side is the
// PC sequencer; the slave side is its environment.
interface inst_pc_control_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) ();

    // Loop controller
    logic          inst_jump_i;
    logic [AW-1:0] inst_jump_addr_i;
    logic          inst_loop_done_i;
    logic [AW-1:0] inst_pc_o;
    logic          loop_en_o;

    // Instruction memory
    logic          inst_rd_en_o;
    logic [DW-1:0] inst_rdata_i;

    // Decoder
    logic [DW-1:0] inst_code_o;
    logic          inst_valid_o;

    modport master (
        input  inst_jump_i, inst_jump_addr_i, inst_loop_done_i, inst_rdata_i,
        output inst_pc_o, loop_en_o, inst_rd_en_o, inst_code_o, inst_valid_o
    );

    modport slave (
        output inst_jump_i, inst_jump_addr_i, inst_loop_done_i, inst_rdata_i,
        input  inst_pc_o, loop_en_o, inst_rd_en_o, inst_code_o, inst_valid_o
    );

endinterface

// File: rtl/inst_fetch_reg.sv
// One-cycle fetch stage: valid follows the read enable by one cycle, matching
// the memory's read latency. The instruction word is passed through while
// valid and held afterwards so the decoder always sees the last fetched word.
module inst_fetch_reg #(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 rd_en_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] code_o
);

    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] code_q, code_d;

    // Next-state: valid tracks the read issue; the hold register captures live data.
    always_comb begin
        valid_d = rd_en_i;
        code_d  = valid_q ? rdata_i : code_q;
    end

    // Stage registers; reset and soft clear both drop any read in flight.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign valid_o = valid_q;
    assign code_o  = valid_q ? rdata_i : code_q;

endmodule

// File: rtl/inst_pc_control.sv
// Program-counter sequencer. Walks the PC through instruction memory,
// following jumps from the loop controller, until the last instruction is
// issued (end address or loop-done). Supports stall, soft clear and a debug
// halt with single stepping. Wrapping past the top of memory is flagged
// with a sticky error.
module inst_pc_control
    import inst_ctrl_pkg::*;
#(
    parameter  int unsigned InstMemDepth     = InstMemDepthDef,
    parameter  int unsigned InstWidth        = InstWidthDef,
    localparam int unsigned InstMemAddrWidth = $clog2(InstMemDepth)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        start_i,
    input  logic                        stall_i,
    input  logic                        dbg_en_i,
    input  logic                        dbg_step_i,
    input  logic                        use_loop_i,
    input  logic [InstMemAddrWidth-1:0] inst_end_addr_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pc_wrap_err_o,
    inst_pc_control_if.master           bus
);

    localparam logic [InstMemAddrWidth-1:0] PcMax = InstMemAddrWidth'(InstMemDepth - 1);

    inst_state_e                 state_q, state_d;
    logic [InstMemAddrWidth-1:0] pc_q, pc_d;
    logic                        wrap_err_q, wrap_err_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic                        loop_en_q, loop_en_d;
    logic                        advance;
    logic                        last_inst;
    logic                        srst;

    assign srst      = rst_i | clr_i;
    assign advance   = (state_q == ST_RUN) && !stall_i && (!dbg_en_i || dbg_step_i);
    assign last_inst = use_loop_i ? bus.inst_loop_done_i : (pc_q == inst_end_addr_i);

    // Next-state and PC: finish beats jump beats increment, all gated by advance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wrap_err_d = wrap_err_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if (last_inst) begin
                        state_d = ST_DONE;
                    end else if (bus.inst_jump_i) begin
                        pc_d = bus.inst_jump_addr_i;
                    end else if (pc_q == PcMax) begin
                        pc_d       = '0;
                        wrap_err_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
        done_d    = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
        loop_en_d = (state_d == ST_RUN);
    end

    // State, PC and registered status outputs; clear behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            wrap_err_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            loop_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wrap_err_q <= wrap_err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            loop_en_q  <= loop_en_d;
        end
    end

    inst_fetch_reg #(
        .DataWidth (InstWidth)
    ) u_fetch (
        .clk_i   (clk_i),
        .srst_i  (srst),
        .rd_en_i (advance),
        .rdata_i (bus.inst_rdata_i),
        .valid_o (bus.inst_valid_o),
        .code_o  (bus.inst_code_o)
    );

    assign bus.inst_pc_o    = pc_q;
    assign bus.inst_rd_en_o = advance;
    assign bus.loop_en_o    = loop_en_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pc_wrap_err_o    = wrap_err_q;

endmodule
